spm_seq_ctrl: RTL and testbench

//  Sequencer for the serial-parallel multiplier (spm) array of per-bit CSA cells.

---
 rtl/spm_pkg.sv | 24 ++
 rtl/spm_ser_shift.sv | 39 +++
 rtl/spm_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_spm_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spm_pkg
//  Brief    : Shared types and sizing helpers for the spm sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package spm_pkg;

  // Sequencer states; ST_ prefix keeps the literals clear of parameter names
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_TAIL  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } spm_state_e;

  // Counter width able to hold the full operation length 2W+P_LAT+FLUSH
  function automatic int spm_cnt_w(input int w, input int p_lat, input int flush);
    return $clog2(2 * w + p_lat + flush + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spm_ser_shift.sv
`default_nettype none
// ============================================================================
//  Module   : spm_ser_shift
//  Brief    : W-bit shift register with parallel load, arithmetic right shift
//             and serial-in-at-MSB modes (priority in that order).
//  Revision : 1.0 - initial release
// ============================================================================
module spm_ser_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_asr,
  input  logic         i_sin_en,
  input  logic         i_sin,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Shift/load register; load wins over shifting, shifting over serial-in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_asr) begin
      r_q <= {r_q[W-1], r_q[W-1:1]};
    end else if (i_sin_en) begin
      r_q <= {i_sin, r_q[W-1:1]};
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spm_seq_ctrl
//  Brief    : Sequencer for a serial-parallel multiplier array. Accepts a
//             signed (x, y) pair, streams y LSB-first (sign-extended to 2W
//             bits) against a held x, collects the serial product and returns
//             the exact 2W-bit signed product on a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module spm_seq_ctrl #(
  parameter int W     = 8,
  parameter int P_LAT = 1,
  parameter int FLUSH = W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  output logic [W-1:0]   spm_x,
  output logic           spm_y,
  input  logic           spm_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_prod,
  output logic           busy
);

  import spm_pkg::*;

  localparam int CW = spm_cnt_w(W, P_LAT, FLUSH);

  // Terminal counts on the single operation counter (cnt = cycles since accept)
  localparam logic [CW-1:0] c_run_last   = CW'(2 * W - 1);
  localparam logic [CW-1:0] c_tail_last  = CW'(2 * W + P_LAT - 1);
  localparam logic [CW-1:0] c_flush_last = CW'(2 * W + P_LAT + FLUSH);
  localparam logic [CW-1:0] c_cap_first  = CW'(P_LAT);

  spm_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [2*W-1:0]   r_out_prod;
  logic [W-1:0]     r_spm_x;
  logic             r_ydrv;
  logic             r_busy;

  logic             w_accept;
  logic             w_cap;
  logic [W-1:0]     w_y_q;
  logic [2*W-1:0]   w_prod_q;
  logic             w_unused_y;

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  // Product bit k arrives P_LAT cycles after y bit k was driven, so capture
  // starts P_LAT cycles into RUN and continues through TAIL.
  generate
    if (P_LAT == 0) begin : g_cap_nolat
      assign w_cap = (r_state == ST_RUN);
    end else begin : g_cap_lat
      assign w_cap = ((r_state == ST_RUN) && (r_cnt >= c_cap_first)) ||
                     (r_state == ST_TAIL);
    end
  endgenerate

  // y register: arithmetic shift keeps feeding the sign bit once y is exhausted
  spm_ser_shift #(.W(W)) u_y_sh (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (in_y),
    .i_asr      (r_state == ST_RUN),
    .i_sin_en   (1'b0),
    .i_sin      (1'b0),
    .o_q        (w_y_q)
  );

  // Product register: serial bits enter at the MSB, so bit 0 ends at the LSB
  spm_ser_shift #(.W(2 * W)) u_prod_sh (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val ('0),
    .i_asr      (1'b0),
    .i_sin_en   (w_cap),
    .i_sin      (spm_p),
    .o_q        (w_prod_q)
  );

  // Only the serial end of the y register feeds the array
  assign w_unused_y = ^w_y_q[W-1:1];

  // Sequencer FSM with operation counter and registered handshake outputs.
  // FLUSH holds through its terminal count, one cycle beyond the drain
  // length, which yields a handshake-to-valid latency of 2W+P_LAT+FLUSH+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_prod  <= '0;
      r_spm_x     <= '0;
      r_ydrv      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_spm_x    <= in_x;
            r_ydrv     <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_run_last) begin
            if (P_LAT == 0) begin
              r_state <= ST_FLUSH;
              r_spm_x <= '0;
              r_ydrv  <= 1'b0;
            end else begin
              r_state <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_tail_last) begin
            r_state <= ST_FLUSH;
            r_spm_x <= '0;
            r_ydrv  <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == c_flush_last) begin
            r_state     <= ST_DONE;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_out_prod  <= w_prod_q;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_spm_x     <= '0;
          r_ydrv      <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_prod  = r_out_prod;
  assign spm_x     = r_spm_x;
  assign spm_y     = r_ydrv & w_y_q[0];
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spm_seq_ctrl
//  Brief    : Directed and random bench for spm_seq_ctrl with a behavioural
//             serial-parallel multiplier array driving spm_p.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spm_seq_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic [W-1:0]   spm_x;
  logic           spm_y;
  logic           spm_p;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spm_seq_ctrl #(.W(W), .P_LAT(1), .FLUSH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_p     (spm_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  // Behavioural array: accumulate y_bit * sext(x), emit the LSB one cycle
  // later, halve the accumulator. An x=0/y=0 cycle drains it to zero.
  logic signed [2*W+1:0] m_acc;
  logic signed [2*W+1:0] m_t;
  logic                  m_p;

  always_comb m_t = m_acc + (spm_y ? {{(W+2){spm_x[W-1]}}, spm_x} : '0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc <= '0;
      m_p   <= 1'b0;
    end else if (spm_x == '0 && !spm_y) begin
      m_acc <= '0;
      m_p   <= 1'b0;
    end else begin
      m_p   <= m_t[0];
      m_acc <= m_t >>> 1;
    end
  end

  assign spm_p = m_p;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_prod"},  32'(out_prod),  32'd0);
    chk({tag, "_spm_x"},     32'(spm_x),     32'd0);
    chk({tag, "_spm_y"},     32'(spm_y),     32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // One operation: offer, accept, wait for result, optional stall, handshake.
  // intrude: offer a foreign pair mid-RUN. pend: offer (-6,11) during the stall.
  task automatic run_op(input logic signed [7:0] x, input logic signed [7:0] y,
                        input int stall, input bit intrude, input bit pend,
                        input string tag);
    logic [15:0] e;
    int n;
    int lat;
    e         = x * y;
    in_x      = x;
    in_y      = y;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (intrude && lat == 3) begin
        in_x     = 8'd100;
        in_y     = 8'hF9;
        in_valid = 1'b1;
      end
      if (intrude && lat == 6) begin
        chk({tag, "_run_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_run_busy"}, 32'(busy), 32'd1);
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd26);
    for (int s = 0; s < stall; s++) begin
      if (pend) begin
        in_x     = 8'hFA;
        in_y     = 8'd11;
        in_valid = 1'b1;
        chk({tag, "_stall_rdy"}, 32'(in_ready), 32'd0);
      end
      chk({tag, "_stall_vld"},  32'(out_valid), 32'd1);
      chk({tag, "_stall_prod"}, 32'(out_prod),  32'(e));
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk({tag, "_prod"}, 32'(out_prod), 32'(e));
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    int st;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);

    run_op(8'sd3, 8'sd5, 0, 1'b0, 1'b0, "t1");
    run_op(-8'sd1, -8'sd1, 0, 1'b0, 1'b0, "t2_m1m1");
    run_op(-8'sd128, -8'sd128, 0, 1'b0, 1'b0, "t2_minmin");
    run_op(8'sd127, -8'sd128, 0, 1'b0, 1'b0, "t2_maxmin");

    run_op(8'sd20, -8'sd9, 10, 1'b0, 1'b1, "t3");
    run_op(-8'sd6, 8'sd11, 0, 1'b0, 1'b0, "t3_next");

    // Reset while RUN has cnt == 5
    in_x     = 8'h9C;
    in_y     = 8'd77;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("t4_rst");
    rst = 1'b1;
    @(negedge clk);
    run_op(8'sd7, 8'sd9, 0, 1'b0, 1'b0, "t4_after");

    run_op(8'sd5, -8'sd3, 0, 1'b1, 1'b0, "t6");

    for (int i = 0; i < 1000; i++) begin
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_op(8'($urandom), 8'($urandom), st, 1'b0, 1'b0, "t5");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
